// File: rtl/reg_file_clr.sv
// Parametrised register bank: two combinational read ports, one synchronous
// write port, optional r0 hardwiring and write bypass, plus a clear sequencer.
module reg_file_clr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  canWrite,
  input  logic                  clearReq,
  output logic [DATA_WIDTH-1:0] outputData1,
  output logic [DATA_WIDTH-1:0] outputData2,
  output logic                  busy,
  output logic                  clearDone
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  wr_accept;

  // A write is accepted only outside the sweep and never to a hardwired r0.
  always_comb begin
    wr_accept = canWrite && !busy;
    if (ZERO_REG != 0 && writeReg == '0)
      wr_accept = 1'b0;
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = regs[addr];
    if (BYPASS != 0 && wr_accept && writeReg == addr)
      val = writeData;
    if (ZERO_REG != 0 && addr == '0)
      val = '0;
    return val;
  endfunction

  always_comb begin
    outputData1 = read_port(readReg1);
    outputData2 = read_port(readReg2);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (state == S_CLEAR) begin
      regs[cnt] <= '0;
    end else if (wr_accept) begin
      regs[writeReg] <= writeData;
    end
  end

  // busy/clearDone are flopped alongside the state so they track it exactly.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      clearDone <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clearDone <= 1'b0;
          if (clearReq) begin
            state <= S_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            clearDone <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          clearDone <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          clearDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_clr.sv
// Directed bench for reg_file_clr: default config, no-r0/no-bypass config,
// and a 16-bit / 8-entry config, all checked against hand-computed values.
module tb_reg_file_clr;

  logic        clock = 1'b0;
  logic        resetN;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic        we, clr;
  logic [31:0] a_o1, a_o2, b_o1, b_o2;
  logic        a_busy, a_done, b_busy, b_done;

  logic [2:0]  c_ra1, c_ra2, c_wa;
  logic [15:0] c_wd;
  logic        c_we, c_clr;
  logic [15:0] c_o1, c_o2;
  logic        c_busy, c_done;

  int errors = 0;
  int checks = 0;
  int busy_a, done_a, busy_b, done_b;

  always #5 clock = ~clock;

  reg_file_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clock(clock), .resetN(resetN), .readReg1(ra1), .readReg2(ra2),
    .writeReg(wa), .writeData(wd), .canWrite(we), .clearReq(clr),
    .outputData1(a_o1), .outputData2(a_o2), .busy(a_busy), .clearDone(a_done));

  reg_file_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clock(clock), .resetN(resetN), .readReg1(ra1), .readReg2(ra2),
    .writeReg(wa), .writeData(wd), .canWrite(we), .clearReq(clr),
    .outputData1(b_o1), .outputData2(b_o2), .busy(b_busy), .clearDone(b_done));

  reg_file_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(1)) u_c (
    .clock(clock), .resetN(resetN), .readReg1(c_ra1), .readReg2(c_ra2),
    .writeReg(c_wa), .writeData(c_wd), .canWrite(c_we), .clearReq(c_clr),
    .outputData1(c_o1), .outputData2(c_o2), .busy(c_busy), .clearDone(c_done));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetN = 1'b1;
    ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0; clr = 1'b0;
    c_ra1 = '0; c_ra2 = '0; c_wa = '0; c_wd = '0; c_we = 1'b0; c_clr = 1'b0;
    #1 resetN = 1'b0;
    ra1 = 5'd5; ra2 = 5'd31;
    #2;
    check("rst_a_o1", a_o1, 0);
    check("rst_a_o2", a_o2, 0);
    check("rst_b_o1", b_o1, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_c_busy", c_busy, 0);
    tick(); tick();
    resetN = 1'b1;
    tick();

    // 1: basic write then read on both ports
    wa = 5'd5; wd = 32'hDEADBEEF; we = 1'b1; ra1 = 5'd6; ra2 = 5'd6;
    tick();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    check("wr_a_o1", a_o1, 32'hDEADBEEF);
    check("wr_a_o2", a_o2, 32'hDEADBEEF);
    check("wr_b_o1", b_o1, 32'hDEADBEEF);
    ra1 = 5'd6;
    #1;
    check("rd_r6", a_o1, 0);

    // 2: r0 hardwired in u_a, ordinary in u_b
    wa = 5'd0; wd = 32'h1234; we = 1'b1; ra1 = 5'd0;
    #1;
    check("r0_a_wrcyc", a_o1, 0);
    check("r0_b_wrcyc", b_o1, 0);
    tick();
    we = 1'b0;
    #1;
    check("r0_a_after", a_o1, 0);
    check("r0_b_after", b_o1, 32'h1234);

    // 3: bypass in u_a, none in u_b
    wa = 5'd7; wd = 32'hA5A5A5A5; we = 1'b1; ra1 = 5'd7;
    #1;
    check("byp_a", a_o1, 32'hA5A5A5A5);
    check("nobyp_b", b_o1, 0);
    tick();
    we = 1'b0;
    #1;
    check("byp_b_after", b_o1, 32'hA5A5A5A5);

    // 4: fill r1..r31 with index, then sweep
    for (int k = 1; k < 32; k++) begin
      wa = 5'(k); wd = 32'(k); we = 1'b1;
      tick();
    end
    we = 1'b0; ra1 = 5'd3; ra2 = 5'd20;
    #1;
    check("fill_r3", a_o1, 3);
    check("fill_r20", a_o2, 20);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_a = 0; done_a = 0; busy_b = 0; done_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_busy) busy_a++;
      if (a_done) done_a++;
      if (b_busy) busy_b++;
      if (b_done) done_b++;
      if (i == 3) check("sweep_r3_pre", a_o1, 3);
      if (i == 4) begin
        check("sweep_r3_clr", a_o1, 0);
        check("sweep_r20_old", a_o2, 20);
        wa = 5'd20; wd = 32'h77; we = 1'b1;
        #1;
        check("sweep_nobyp", a_o2, 20);
      end
      if (i == 5) begin
        we = 1'b0;
        check("sweep_wr_ignored", a_o2, 20);
      end
      if (i == 10) clr = 1'b1;
      if (i == 11) clr = 1'b0;
      if (i == 32) begin
        check("done_pulse", a_done, 1);
        clr = 1'b1;
      end
      if (i == 33) clr = 1'b0;
      tick();
    end
    check("busy_cycles_a", busy_a, 32);
    check("done_count_a", done_a, 1);
    check("busy_cycles_b", busy_b, 32);
    check("done_count_b", done_b, 1);
    for (int j = 0; j < 32; j++) begin
      ra1 = 5'(j);
      #1;
      check("swept_a", a_o1, 0);
      check("swept_b", b_o1, 0);
    end

    // 5: reset in the middle of a sweep
    wa = 5'd25; wd = 32'h99; we = 1'b1;
    tick();
    we = 1'b0; ra1 = 5'd25; ra2 = 5'd25;
    #1;
    check("pre5_r25", a_o1, 32'h99);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", a_busy, 1);
    resetN = 1'b0;
    #1;
    check("midrst_busy", a_busy, 0);
    check("midrst_r25_a", a_o1, 0);
    check("midrst_r25_b", b_o1, 0);
    check("midrst_done", a_done, 0);
    tick();
    resetN = 1'b1;
    done_a = 0; busy_a = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_done) done_a++;
      if (a_busy) busy_a++;
      tick();
    end
    check("post_rst_nodone", done_a, 0);
    check("post_rst_nobusy", busy_a, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    done_a = 0; busy_a = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_done) done_a++;
      if (a_busy) busy_a++;
      tick();
    end
    check("resweep_busy", busy_a, 32);
    check("resweep_done", done_a, 1);

    // 6: 16-bit data, 8-entry instance
    c_wa = 3'd5; c_wd = 16'hBEEF; c_we = 1'b1;
    tick();
    c_we = 1'b0; c_ra1 = 3'd5; c_ra2 = 3'd5;
    #1;
    check("c_wr_o1", c_o1, 16'hBEEF);
    check("c_wr_o2", c_o2, 16'hBEEF);
    c_ra1 = 3'd6;
    #1;
    check("c_rd_r6", c_o1, 0);
    c_wa = 3'd0; c_wd = 16'h1234; c_we = 1'b1; c_ra1 = 3'd0;
    #1;
    check("c_r0_wrcyc", c_o1, 0);
    tick();
    c_we = 1'b0;
    #1;
    check("c_r0_after", c_o1, 0);
    c_wa = 3'd7; c_wd = 16'hA5A5; c_we = 1'b1; c_ra1 = 3'd7;
    #1;
    check("c_byp", c_o1, 16'hA5A5);
    tick();
    for (int k = 1; k < 8; k++) begin
      c_wa = 3'(k); c_wd = 16'(k); c_we = 1'b1;
      tick();
    end
    c_we = 1'b0; c_ra1 = 3'd3; c_ra2 = 3'd6;
    c_clr = 1'b1;
    tick();
    c_clr = 1'b0;
    busy_a = 0; done_a = 0;
    for (int i = 0; i < 12; i++) begin
      if (c_busy) busy_a++;
      if (c_done) done_a++;
      if (i == 3) check("c_r3_pre", c_o1, 3);
      if (i == 4) begin
        check("c_r3_clr", c_o1, 0);
        check("c_r6_old", c_o2, 6);
      end
      tick();
    end
    check("c_busy_cycles", busy_a, 8);
    check("c_done_count", done_a, 1);
    for (int j = 0; j < 8; j++) begin
      c_ra1 = 3'(j);
      #1;
      check("c_swept", c_o1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_clr.md
Name: reg_file_clr

Overview:
- Parametrised, clocked successor to the CPU register bank.
- Provides two combinational read ports and one synchronous write port.
- Optional register-0 hardwiring and optional write-to-read bypass.
- Adds a one-register-per-cycle clear sequencer, used by the control unit for soft reset and context flush.
- Sits between the decode stage (rs/rt/rd addresses) and the ALU and write-back muxes.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
ZERO_REG, 1, 1: register 0 always reads 0 and writes to it are discarded; 0: register 0 is an ordinary register
BYPASS, 1, 1: a same-cycle write to an address being read is forwarded to the read port; 0: reads return the stored value

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous, active-low reset
readReg1  input  ADDR_WIDTH  read address, port 1 ($rs)
readReg2  input  ADDR_WIDTH  read address, port 2 ($rt)
writeReg  input  ADDR_WIDTH  write address
writeData  input  DATA_WIDTH  write data
canWrite  input  1  write enable, sampled on the rising clock edge
clearReq  input  1  starts a clear sweep; sampled only in IDLE
outputData1  output  DATA_WIDTH  read data, port 1
outputData2  output  DATA_WIDTH  read data, port 2
busy  output  1  high while the clear sweep runs
clearDone  output  1  one-cycle pulse when the sweep finishes

Behaviour:
- Reset: resetN low asynchronously zeroes all DEPTH registers, FSM goes to IDLE, sweep counter goes to 0, busy=0, clearDone=0. outputData1/2 therefore read 0 during reset. Deassertion is taken synchronously at the next edge.
- Write: on a rising edge with canWrite=1 and busy=0, regs[writeReg] <= writeData. Write latency is 1 edge.
  - ZERO_REG=1 and writeReg=0: the write is discarded.
  - canWrite is ignored while busy=1.
- Read: purely combinational, 0 cycle latency. outputDataN = regs[readRegN], subject to the two overrides below.
  - ZERO_REG=1 and readRegN=0: output 0, which overrides the bypass.
  - BYPASS=1, canWrite=1, busy=0, writeReg==readRegN, and the write is not discarded: output writeData.
  - Both ports may address the same register; each port resolves independently.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clearReq=1 at an edge -> CLEAR, counter <= 0. busy goes high from that edge. A write presented in the same cycle as the accepted clearReq is still performed, because busy was 0 at that edge.
  - CLEAR: each edge sets regs[counter] <= 0 and counter <= counter+1. On the edge that clears DEPTH-1 -> DONE. The counter wraps to 0. The sweep takes exactly DEPTH cycles in CLEAR.
  - DONE: busy=0, clearDone=1 for this single cycle -> IDLE on the next edge.
  - clearReq while in CLEAR or DONE is ignored; it is not queued.
  - busy is a registered output: 1 in CLEAR, 0 in IDLE and DONE.
- Reads during CLEAR return current array contents: registers already swept read 0, the rest read their old values. Bypass is disabled while busy=1.
- Reset mid-sweep: everything returns to reset values and no clearDone pulse is issued.
- No X propagation: every register is reset, so no read may return X after reset.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5 and on the next cycle read r5 on both ports -> both ports = 0xDEADBEEF. Read r6 -> 0.
2. ZERO_REG=1: write 0x1234 to r0 -> r0 reads 0 in the write cycle and afterwards. Rerun with ZERO_REG=0 -> r0 reads 0x1234 after the edge.
3. BYPASS=1: in a single cycle, canWrite=1, writeReg=7, writeData=0xA5A5A5A5, readReg1=7 -> outputData1=0xA5A5A5A5 before the edge. BYPASS=0 -> old value (0) until after the edge.
4. Fill r1..r31 with the value of their index, then pulse clearReq -> busy high for exactly 32 cycles. r3 reads 0 after 4 sweep edges while r20 still reads 20. clearDone pulses once, then all registers read 0. Writes attempted during busy have no effect.
5. Start a sweep and assert resetN=0 on sweep cycle 10 -> busy=0 and all reads 0 immediately; after reset release there is no clearDone pulse and a fresh clearReq is accepted normally.
6. Parameter sweep with DATA_WIDTH=16, ADDR_WIDTH=3 -> 8-cycle sweep, 16-bit data, and all of scenarios 1-4 pass with scaled values.
